pinwheel_data_target: RTL

//  Responder on the pinwheel core data bus (bus_addr/wdata/wmask/wren out, rdata back one cycle later).

---
 rtl/pinwheel_data_target_if.sv | 13 +
 rtl/pinwheel_data_target.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pinwheel_data_target_if.sv
// rtl/pinwheel_data_target_if.sv - pinwheel core data bus: address/store out, read data back
interface pinwheel_data_target_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_wren;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, output bus_wdata, output bus_wmask, output bus_wren,
                  input  bus_rdata);
  modport slave  (input  bus_addr, input  bus_wdata, input  bus_wmask, input  bus_wren,
                  output bus_rdata);
endinterface

// File: rtl/pinwheel_data_target.sv
// rtl/pinwheel_data_target.sv - data RAM plus console FIFO, tick counter and test latch on the core data bus
module pinwheel_data_target #(
  parameter int DATA_WORDS = 16384,
  parameter int CON_DEPTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  pinwheel_data_target_if.slave       bus,
  output logic                        con_valid,
  output logic [7:0]                  con_data,
  input  logic                        con_ready,
  output logic                        test_done,
  output logic                        test_pass,
  output logic                        bus_error
);
  localparam int IW = $clog2(DATA_WORDS);
  localparam int CW = $clog2(CON_DEPTH);
  localparam logic [CW:0] PTR_ONE = (CW+1)'(1);
  localparam logic [CW:0] DEPTH_P = (CW+1)'(CON_DEPTH);

  typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_REG} rd_sel_t;

  // Address decode: the top nibble picks the region, word offset picks the register.
  logic [3:0]    tag;
  logic [5:0]    reg_off;
  logic [IW-1:0] ram_idx;
  logic          is_ram, is_reg, is_quiet;
  assign tag      = bus.bus_addr[31:28];
  assign reg_off  = bus.bus_addr[7:2];
  assign ram_idx  = bus.bus_addr[IW+1:2];
  assign is_ram   = (tag == 4'h8);
  assign is_reg   = (tag == 4'hF);
  assign is_quiet = (tag == 4'h0) || (tag == 4'hE);

  // Aliased upper address bits and byte offset are deliberately not decoded.
  logic unused_addr;
  assign unused_addr = ^bus.bus_addr;

  logic [31:0] mem [DATA_WORDS];
  logic [31:0] ram_q;
  logic [7:0]  con_buf [CON_DEPTH];
  logic [CW:0] head, tail, count;
  logic        overflow, full, empty;
  logic [31:0] ticks;
  rd_sel_t     rd_sel;
  logic [31:0] reg_q, reg_rd;

  assign count     = tail - head;
  assign full      = (count == DEPTH_P);
  assign empty     = (count == '0);
  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : con_buf[head[CW-1:0]];

  // A push while full is only accepted if the head leaves in the same cycle.
  logic pop, push_req, push_ok, push_drop, ovf_clear, test_wr, bad_store;
  assign pop       = con_valid && con_ready;
  assign push_req  = bus.bus_wren && is_reg && (reg_off == 6'd0) && bus.bus_wmask[0];
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;
  assign ovf_clear = bus.bus_wren && is_reg && (reg_off == 6'd1) && bus.bus_wdata[31] && bus.bus_wmask[3];
  assign test_wr   = bus.bus_wren && is_reg && (reg_off == 6'd3) && (bus.bus_wmask != 4'b0000);
  assign bad_store = bus.bus_wren && !is_ram && !is_reg && !is_quiet;

  // Register read mux, sampled from pre-edge state.
  always_comb begin
    reg_rd = 32'h0;
    case (reg_off)
      6'd1:    reg_rd = {overflow, full, empty, 21'b0, 8'(count)};
      6'd2:    reg_rd = ticks;
      6'd3:    reg_rd = {31'b0, test_pass};
      default: reg_rd = 32'h0;
    endcase
  end

  // Data RAM: lane-masked store, registered read returns the old word on a collision.
  always_ff @(posedge clock) begin
    if (bus.bus_wren && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.bus_wmask[i]) mem[ram_idx][8*i +: 8] <= bus.bus_wdata[8*i +: 8];
      end
    end
    ram_q <= mem[ram_idx];
  end

  // Console byte storage; only the pointers are reset.
  always_ff @(posedge clock) begin
    if (push_ok) con_buf[tail[CW-1:0]] <= bus.bus_wdata[7:0];
  end

  // Console pointers and overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)     head <= head + PTR_ONE;
      if (push_ok) tail <= tail + PTR_ONE;
      if (push_drop)      overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  // Free-running tick counter, test result latch and sticky unmapped-store error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ticks     <= 32'h0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      ticks <= ticks + 32'd1;
      if (test_wr && !test_done) begin
        test_done <= 1'b1;
        test_pass <= bus.bus_wdata[0];
      end
      if (bad_store) bus_error <= 1'b1;
    end
  end

  // Remember which source answers the read presented this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel <= RD_ZERO;
      reg_q  <= 32'h0;
    end else begin
      rd_sel <= is_ram ? RD_RAM : (is_reg ? RD_REG : RD_ZERO);
      reg_q  <= reg_rd;
    end
  end

  assign bus.bus_rdata = (rd_sel == RD_RAM) ? ram_q :
                         (rd_sel == RD_REG) ? reg_q : 32'h0;
endmodule
